// File: rtl/legv8_pkg.sv
// Shared types and constants for the LegV8 fetch path.
// The PS encodings let the control path map pc_advance straight onto the PC select.
package legv8_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HAVE = 2'b10
  } fetch_state_e;

  function automatic logic [1:0] pc_select(input logic advance);
    return advance ? PS_INC : PS_HOLD;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Clearable up-counter that counts cycles spent waiting on memory.
// The terminal flag is raised while the count equals TIMEOUT-1.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !term_o) begin
      count_d = count_q + 1'b1;
    end
  end

  assign term_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches the instruction at PC over a req/ack memory port and holds it for
// decode under valid/ready; pulses pc_advance once per completed fetch.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] PC,
  output logic              pc_advance,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  import legv8_pkg::*;

  fetch_state_e state_q, state_d;

  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pc_advance_q, pc_advance_d;
  logic               fetch_err_q, fetch_err_d;

  logic              tmo_term;
  logic [ADDR_W-1:0] fetch_addr;
  logic              issue_ok;
  logic              issue_bad;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q != ST_REQ),
    .inc_i   (state_q == ST_REQ),
    .term_o  (tmo_term)
  );

  // While pc_advance is high the PC register steps on this very edge, so the
  // follow-on address comes from the address just fetched rather than PC.
  assign fetch_addr = pc_advance_q ? (mem_addr_q + ADDR_W'(4)) : PC;
  assign issue_ok   = enable && !fetch_err_q && (fetch_addr[1:0] == 2'b00);
  assign issue_bad  = enable && !fetch_err_q && (fetch_addr[1:0] != 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (issue_ok) state_d = ST_REQ;
        ST_REQ: begin
          if (mem_ack)       state_d = ST_HAVE;
          else if (tmo_term) state_d = ST_IDLE;
        end
        ST_HAVE: if (instr_ready) state_d = issue_ok ? ST_REQ : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    pc_advance_d  = 1'b0;
    fetch_err_d   = fetch_err_q;
    if (flush) begin
      instr_valid_d = 1'b0;
      mem_req_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_ok) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_addr;
          end else if (issue_bad) begin
            fetch_err_d = 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            instr_d       = mem_data;
            instr_pc_d    = mem_addr_q;
            instr_valid_d = 1'b1;
            mem_req_d     = 1'b0;
            pc_advance_d  = 1'b1;
          end else if (tmo_term) begin
            fetch_err_d = 1'b1;
            mem_req_d   = 1'b0;
          end
        end
        ST_HAVE: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            if (issue_ok) begin
              mem_req_d  = 1'b1;
              mem_addr_d = fetch_addr;
            end else if (issue_bad) begin
              fetch_err_d = 1'b1;
            end
          end
        end
        default: mem_req_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      pc_advance_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      pc_advance_q  <= pc_advance_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign pc_advance  = pc_advance_q;
  assign fetch_err   = fetch_err_q;

endmodule
